rww_reg_bank: RTL

RWW_REG_BANK -- requirements
Module: rww_reg_bank

---
 rtl/rww_reg_bank.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/rww_reg_bank.sv
// rww_reg_bank: key-protected register bank with CPU and logic write paths.
// CPU access is gated by mode enables; bank writes need a two-key unlock
// sequence at LOCK_ADDR. Logic writes (efuse path) ignore the lock.
// Optional macro RWW_REG_BANK_TIMEOUT_EN adds an idle counter that relocks
// the bank after TIMEOUT idle cycles in UNLOCKED.
module rww_reg_bank #(
  parameter int unsigned DW                = 8,
  parameter int unsigned AW                = 8,
  parameter int unsigned NUM_REG           = 4,
  parameter logic [AW-1:0] BASE_ADDR       = AW'(8'h10),
  parameter logic [AW-1:0] LOCK_ADDR       = AW'(8'h0F),
  parameter logic [DW-1:0] KEY0            = DW'(8'h5A),
  parameter logic [DW-1:0] KEY1            = DW'(8'hA5),
  parameter int unsigned TIMEOUT           = 255,
  parameter logic [NUM_REG*DW-1:0] DEFAULT_VAL = '0,
  parameter logic SUPPORT_TEST_MODE        = 1'b1,
  parameter logic SUPPORT_CFG_MODE         = 1'b1,
  parameter logic SUPPORT_SPI_EN           = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wen,
  input  logic                  i_ren,
  input  logic [AW-1:0]         i_addr,
  input  logic [DW-1:0]         i_wdata,
  input  logic                  i_test_st_reg_en,
  input  logic                  i_cfg_st_reg_en,
  input  logic                  i_spi_ctrl_reg_en,
  input  logic                  i_efuse_ctrl_reg_en,
  input  logic [NUM_REG-1:0]    i_lgc_wen,
  input  logic [NUM_REG*DW-1:0] i_lgc_wdata,
  output logic [DW-1:0]         o_rdata,
  output logic                  o_rvalid,
  output logic [NUM_REG*DW-1:0] o_reg_data,
  output logic                  o_locked,
  output logic                  o_wr_err
);

  if (NUM_REG < 1 || NUM_REG > 16) begin : g_bad_num_reg
    $error("rww_reg_bank: NUM_REG must be in 1..16");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("rww_reg_bank: TIMEOUT must be in 1..65535");
  end

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    KEY_WAIT = 2'd1,
    UNLOCKED = 2'd2
  } lock_state_t;

  lock_state_t          state, state_nxt;
  logic                 permitted;
  logic                 cpu_wr;
  logic                 lock_hit;
  logic                 bank_hit;
  logic [AW-1:0]        offset;
  logic                 bank_wr_ok;
  logic                 wr_drop;
  logic                 timeout;
  logic [NUM_REG-1:0]   cpu_sel;
  logic [DW-1:0]        rd_val;
  logic [DW-1:0]        regs [NUM_REG];

  assign permitted = (i_test_st_reg_en  & SUPPORT_TEST_MODE) |
                     (i_cfg_st_reg_en   & SUPPORT_CFG_MODE)  |
                     (i_spi_ctrl_reg_en & SUPPORT_SPI_EN);
  assign cpu_wr    = i_wen & permitted;
  // Addresses below BASE_ADDR wrap to large offsets, so one compare covers both ends.
  assign offset    = i_addr - BASE_ADDR;
  assign bank_hit  = (offset < AW'(NUM_REG));
  assign lock_hit  = (i_addr == LOCK_ADDR);
  assign o_locked  = (state != UNLOCKED);

`ifdef RWW_REG_BANK_TIMEOUT_EN
  localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT - 1);
  logic [15:0] idle_cnt;

  assign timeout = (state == UNLOCKED) && !cpu_wr && (idle_cnt == IDLE_LAST);

  // Idle counter: runs only while UNLOCKED, restarts on any permitted CPU write.
  always_ff @(posedge i_clk) begin
    if (i_rst || (state != UNLOCKED) || cpu_wr || timeout) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Lock state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= LOCKED;
    end else begin
      state <= state_nxt;
    end
  end

  // Lock transitions and qualification of CPU bank writes.
  always_comb begin
    state_nxt  = state;
    bank_wr_ok = 1'b0;
    wr_drop    = 1'b0;
    case (state)
      LOCKED: begin
        if (cpu_wr) begin
          if (lock_hit) begin
            if (i_wdata == KEY0) state_nxt = KEY_WAIT;
          end else begin
            wr_drop = bank_hit;
          end
        end
      end
      KEY_WAIT: begin
        // Any permitted write ends the key sequence; only KEY1 at LOCK_ADDR completes it.
        if (cpu_wr) begin
          state_nxt = (lock_hit && (i_wdata == KEY1)) ? UNLOCKED : LOCKED;
          wr_drop   = bank_hit;
        end
      end
      UNLOCKED: begin
        if (cpu_wr) begin
          if (lock_hit) state_nxt = LOCKED;
          else          bank_wr_ok = bank_hit;
        end else if (timeout) begin
          state_nxt = LOCKED;
        end
      end
      default: state_nxt = LOCKED;
    endcase
  end

  // Per-register CPU write select.
  always_comb begin
    cpu_sel = '0;
    for (int unsigned k = 0; k < NUM_REG; k++) begin
      cpu_sel[k] = bank_wr_ok && (offset == AW'(k));
    end
  end

  // Read data source: lock state, bank register, or zero.
  always_comb begin
    rd_val = '0;
    if (permitted) begin
      if (lock_hit) begin
        rd_val = DW'(state);
      end else begin
        for (int unsigned k = 0; k < NUM_REG; k++) begin
          if (offset == AW'(k)) rd_val = regs[k];
        end
      end
    end
  end

  // Register storage: CPU write beats logic write; a dropped CPU write lets logic through.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned k = 0; k < NUM_REG; k++) begin
        regs[k] <= DEFAULT_VAL[k*DW +: DW];
      end
    end else begin
      for (int unsigned k = 0; k < NUM_REG; k++) begin
        if (cpu_sel[k]) begin
          regs[k] <= i_wdata;
        end else if (i_lgc_wen[k] && i_efuse_ctrl_reg_en) begin
          regs[k] <= i_lgc_wdata[k*DW +: DW];
        end
      end
    end
  end

  // Registered read response and write-error pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rvalid <= 1'b0;
      o_rdata  <= '0;
      o_wr_err <= 1'b0;
    end else begin
      o_rvalid <= i_ren;
      o_wr_err <= wr_drop;
      if (i_ren) o_rdata <= rd_val;
    end
  end

  // Flatten register contents onto the packed output bus.
  always_comb begin
    o_reg_data = '0;
    for (int unsigned k = 0; k < NUM_REG; k++) begin
      o_reg_data[k*DW +: DW] = regs[k];
    end
  end

endmodule
